perceptron_weight_bank: RTL and testbench
=========================================

// Module: perceptron_weight_bank
// PURPOSE
// - Parametrised successor to the bias-free perceptron weight table: LANES independent weight
//   memories, each indexed by its own IDX_BITS hash, with a 1-cycle registered read port.
// - Training is internal: in-bank saturating +/-1 read-modify-write with per-lane mask and
//   hazard forwarding, instead of an externally computed write-back.
// - Self-clear FSM zeroes the bank after reset or on request. Sits between the index hash
//   stage and the perceptron adder tree; the branch-resolve stage drives the update port.
// PARAMETERS
// - LANES     48   number of weights per prediction (one memory per lane)
// - W_BITS    3    signed two's-complement weight width
// - IDX_BITS  16   per-lane index width; depth per lane = 2**IDX_BITS
// PORTS
// - clk         in   1                single clock, all logic on posedge
// - rst_n       in   1                asynchronous, active-low reset
// - rd_valid    in   1                read request
// - rd_index    in   LANES*IDX_BITS   lane i index = rd_index[i*IDX_BITS +: IDX_BITS]
// - rd_weights  out  LANES*W_BITS     lane i weight = rd_weights[i*W_BITS +: W_BITS]
// - rd_valid_o  out  1                rd_weights valid (rd_valid delayed 1 cycle)
// - upd_valid   in   1                training request
// - upd_index   in   LANES*IDX_BITS   per-lane update index, same slicing as rd_index
// - upd_dir     in   LANES            1 = increment, 0 = decrement
// - upd_mask    in   LANES            1 = train this lane, 0 = leave unchanged
// - clear_req   in   1                pulse: re-zero whole bank
// - busy        out  1                clear in progress; reads and updates ignored
// BEHAVIOUR
// - Reset: rd_weights=0, rd_valid_o=0, busy=1, FSM=CLEAR, clr_addr=0, U1/U2 valid=0.
// - FSM CLEAR: each cycle write 0 at clr_addr in every lane, clr_addr++.
//   On clr_addr == 2**IDX_BITS-1, write it, then go IDLE; busy=0 from the next cycle.
//   Clear takes exactly 2**IDX_BITS cycles.
// - FSM IDLE: clear_req=1 -> CLEAR with clr_addr=0 next cycle; busy=1 from that cycle.
//   clear_req while in CLEAR is ignored (no restart).
// - rst_n low mid-clear: async abort; the sweep restarts at 0 after release.
// - Read: accepted when rd_valid && !busy. rd_weights registered next cycle, rd_valid_o=1
//   that cycle. rd_weights holds its value when there is no read. rd_valid while busy:
//   rd_valid_o=0, rd_weights unchanged.
// - Update stage U1: accepted when upd_valid && !busy; latch index/dir/mask, read old weights.
// - Update stage U2 (next cycle): new = sat(old + (dir ? +1 : -1)), range
//   [-2**(W_BITS-1), 2**(W_BITS-1)-1]; write only lanes with mask=1.
// - Forwarding (mandatory): U1 lane i index == U2 lane i index && U2 mask[i] -> U1 uses U2's
//   new value. Back-to-back updates to one entry accumulate exactly.
// - An in-flight U2 write completes even if clear_req arrives that cycle; CLEAR begins next cycle.
// - Same lane/index read while U2 writes it: read returns the pre-write value (see macro).
// - Lanes are fully independent; equal indices in different lanes do not interact.
// CONFIGURATION
// - PWT_BYPASS_EN defined: a read hitting a same-cycle U2 write in that lane returns the new
//   (post-write) value.
// - PWT_BYPASS_EN undefined: the read returns the old value. No other behaviour differs.
// TESTING (IDX_BITS=4, LANES=4, W_BITS=3 unless noted)
// - Reset release -> busy=1 for 16 cycles, then 0; read of all indices -> every lane 0.
// - Lane0 idx5: 4 updates (dir=1, mask=0001) on separate cycles -> read 3 (0,1,2,3; sat at 3).
//   Then 8 decrements -> 3'b100 (-4).
// - Two updates to lane0 idx5 on consecutive cycles, dir=1 from 0 -> read 2 (forwarding).
// - mask=0101, dir=1, idx 7 on all lanes -> lanes 0,2 = 1; lanes 1,3 = 0.
//   Lane1 idx3 untouched by lane0 idx3 update.
// - Read idx5 lane0 in the cycle U2 writes 1 over 0 -> 0 without macro, 1 with PWT_BYPASS_EN.
// - clear_req after training -> busy 16 cycles, all reads 0.
//   rst_n low at clear cycle 8 -> fresh 16-cycle clear; updates during busy leave no effect.

Source files
------------

// File: rtl/perceptron_weight_bank_if.sv
// Bus bundle for perceptron_weight_bank: read port, training port, and clear control/status.
interface perceptron_weight_bank_if #(
   parameter int LANES    = 48,
   parameter int W_BITS   = 3,
   parameter int IDX_BITS = 16
);
   logic                      rd_valid;
   logic [LANES*IDX_BITS-1:0] rd_index;
   logic [LANES*W_BITS-1:0]   rd_weights;
   logic                      rd_valid_o;
   logic                      upd_valid;
   logic [LANES*IDX_BITS-1:0] upd_index;
   logic [LANES-1:0]          upd_dir;
   logic [LANES-1:0]          upd_mask;
   logic                      clear_req;
   logic                      busy;

   modport master (
      output rd_valid, rd_index, upd_valid, upd_index, upd_dir, upd_mask, clear_req,
      input  rd_weights, rd_valid_o, busy
   );

   modport slave (
      input  rd_valid, rd_index, upd_valid, upd_index, upd_dir, upd_mask, clear_req,
      output rd_weights, rd_valid_o, busy
   );
endinterface

// File: rtl/perceptron_weight_bank.sv
// LANES independent saturating weight memories with registered reads, in-bank +/-1 training
// and a self-clear sweep. Define PWT_BYPASS_EN to make reads see a same-cycle training write.
module perceptron_weight_bank #(
   parameter int LANES    = 48,
   parameter int W_BITS   = 3,
   parameter int IDX_BITS = 16
) (
   input logic                      clk,
   input logic                      rst_n,
   perceptron_weight_bank_if.slave  bus
);
   localparam int                  DEPTH     = 1 << IDX_BITS;
   localparam logic [W_BITS-1:0]   W_MAX     = {1'b0, {(W_BITS-1){1'b1}}};
   localparam logic [W_BITS-1:0]   W_MIN     = {1'b1, {(W_BITS-1){1'b0}}};
   localparam logic [IDX_BITS-1:0] LAST_ADDR = '1;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t              state;
   logic [IDX_BITS-1:0] clr_addr;
   logic [W_BITS-1:0]   mem [LANES][DEPTH];

   logic [IDX_BITS-1:0] rd_idx   [LANES];
   logic [IDX_BITS-1:0] upd_idx  [LANES];
   logic [IDX_BITS-1:0] u2_index [LANES];
   logic [W_BITS-1:0]   u2_old   [LANES];
   logic [W_BITS-1:0]   u2_new   [LANES];
   logic [W_BITS-1:0]   fwd_old  [LANES];
   logic [W_BITS-1:0]   rd_data  [LANES];
   logic [LANES-1:0]    u2_dir;
   logic [LANES-1:0]    u2_mask;
   logic                u2_valid;
   logic [LANES*W_BITS-1:0] rd_next;

   logic clearing;
   logic rd_acc;
   logic upd_acc;
   logic u2_wr;

   assign clearing = (state == ST_CLEAR);
   assign rd_acc   = bus.rd_valid && !clearing;
   assign upd_acc  = bus.upd_valid && !clearing;
   assign u2_wr    = u2_valid && !clearing;

   // U1 takes U2's fresh value on an index hit so back-to-back training accumulates exactly.
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < LANES; i++) begin
         rd_idx[i]  = bus.rd_index[i*IDX_BITS +: IDX_BITS];
         upd_idx[i] = bus.upd_index[i*IDX_BITS +: IDX_BITS];
         u2_new[i]  = u2_old[i];
         if (u2_dir[i] && (u2_old[i] != W_MAX))
            u2_new[i] = u2_old[i] + W_BITS'(1);
         else if (!u2_dir[i] && (u2_old[i] != W_MIN))
            u2_new[i] = u2_old[i] - W_BITS'(1);
         if (u2_wr && u2_mask[i] && (u2_index[i] == upd_idx[i]))
            fwd_old[i] = u2_new[i];
         else
            fwd_old[i] = mem[i][upd_idx[i]];
         rd_data[i] = mem[i][rd_idx[i]];
`ifdef PWT_BYPASS_EN
         if (u2_wr && u2_mask[i] && (u2_index[i] == rd_idx[i]))
            rd_data[i] = u2_new[i];
`endif
         rd_next[i*W_BITS +: W_BITS] = rd_data[i];
      end
   end

   // Clear sweep walks every address once; a request during the sweep does not restart it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
         bus.busy <= 1'b1;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_addr == LAST_ADDR) begin
                  state    <= ST_IDLE;
                  clr_addr <= '0;
                  bus.busy <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + IDX_BITS'(1);
               end
            end
            ST_IDLE: begin
               if (bus.clear_req) begin
                  state    <= ST_CLEAR;
                  clr_addr <= '0;
                  bus.busy <= 1'b1;
               end
            end
            default: begin
               state    <= ST_CLEAR;
               clr_addr <= '0;
               bus.busy <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (clearing)
            mem[i][clr_addr] <= '0;
         else if (u2_wr && u2_mask[i])
            mem[i][u2_index[i]] <= u2_new[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_weights <= '0;
         bus.rd_valid_o <= 1'b0;
      end else begin
         bus.rd_valid_o <= rd_acc;
         if (rd_acc)
            bus.rd_weights <= rd_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u2_valid <= 1'b0;
         u2_dir   <= '0;
         u2_mask  <= '0;
         for (int i = 0; i < LANES; i++) begin
            u2_index[i] <= '0;
            u2_old[i]   <= '0;
         end
      end else begin
         u2_valid <= upd_acc;
         if (upd_acc) begin
            u2_dir  <= bus.upd_dir;
            u2_mask <= bus.upd_mask;
            for (int i = 0; i < LANES; i++) begin
               u2_index[i] <= upd_idx[i];
               u2_old[i]   <= fwd_old[i];
            end
         end
      end
   end
endmodule

// File: tb/tb_perceptron_weight_bank.sv
// Directed scoreboard bench for perceptron_weight_bank with LANES=4, W_BITS=3, IDX_BITS=4.
module tb_perceptron_weight_bank;
   localparam int LANES    = 4;
   localparam int W_BITS   = 3;
   localparam int IDX_BITS = 4;
   localparam int DEPTH    = 16;
   localparam int LI       = LANES * IDX_BITS;
   localparam int LW       = LANES * W_BITS;
   localparam int CLR_CYC  = 16;
   localparam int W_MAXV   = 3;
   localparam int W_MINV   = -4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   perceptron_weight_bank_if #(.LANES(LANES), .W_BITS(W_BITS), .IDX_BITS(IDX_BITS)) bus ();

   perceptron_weight_bank #(.LANES(LANES), .W_BITS(W_BITS), .IDX_BITS(IDX_BITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // m_now holds every accepted update; m_d1 lags by one issue cycle, which is what a read sees.
   int          m_now [LANES][DEPTH];
   int          m_d1  [LANES][DEPTH];
   logic [LW-1:0] exp_q [$];
   logic [LW-1:0] last_w;
   logic        exp_valid;
   int          busy_cnt;
   int          total;
   int          bad;
   string       step;

   function automatic logic [LI-1:0] idx4(input int a, input int b, input int c, input int d);
      logic [LI-1:0] v;
      v[3:0]   = a[3:0];
      v[7:4]   = b[3:0];
      v[11:8]  = c[3:0];
      v[15:12] = d[3:0];
      return v;
   endfunction

   function automatic logic [LI-1:0] idx_all(input int k);
      return idx4(k, k, k, k);
   endfunction

   task automatic zero_model();
      for (int i = 0; i < LANES; i++)
         for (int k = 0; k < DEPTH; k++) begin
            m_now[i][k] = 0;
            m_d1[i][k]  = 0;
         end
   endtask

   task automatic drive_idle();
      bus.rd_valid  = 1'b0;
      bus.rd_index  = '0;
      bus.upd_valid = 1'b0;
      bus.upd_index = '0;
      bus.upd_dir   = '0;
      bus.upd_mask  = '0;
      bus.clear_req = 1'b0;
   endtask

   task automatic checkOutput();
      total++;
      assert (bus.busy === (busy_cnt != 0)) else begin
         bad++;
         $error("[TB] FAIL %s busy observed=%0b expected=%0b", step, bus.busy, (busy_cnt != 0));
      end
      total++;
      assert (bus.rd_valid_o === exp_valid) else begin
         bad++;
         $error("[TB] FAIL %s rd_valid_o observed=%0b expected=%0b", step, bus.rd_valid_o, exp_valid);
      end
      if (exp_valid && (exp_q.size() > 0))
         last_w = exp_q.pop_front();
      total++;
      assert (bus.rd_weights === last_w) else begin
         bad++;
         $error("[TB] FAIL %s rd_weights observed=%h expected=%h", step, bus.rd_weights, last_w);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [LI-1:0] ridx,
                                input logic uv, input logic [LI-1:0] uidx,
                                input logic [LANES-1:0] udir, input logic [LANES-1:0] umask,
                                input logic clr);
      logic [LW-1:0] ev;
      logic          acc;
      int            ri;
      int            ui;
      int            v;
      bus.rd_valid  = rv;
      bus.rd_index  = ridx;
      bus.upd_valid = uv;
      bus.upd_index = uidx;
      bus.upd_dir   = udir;
      bus.upd_mask  = umask;
      bus.clear_req = clr;
      acc       = (busy_cnt == 0);
      exp_valid = rv && acc;
      ev        = '0;
      if (rv && acc) begin
         for (int i = 0; i < LANES; i++) begin
            ri = int'(ridx[i*IDX_BITS +: IDX_BITS]);
`ifdef PWT_BYPASS_EN
            v = m_now[i][ri];
`else
            v = m_d1[i][ri];
`endif
            ev[i*W_BITS +: W_BITS] = v[W_BITS-1:0];
         end
         exp_q.push_back(ev);
      end
      m_d1 = m_now;
      if (uv && acc) begin
         for (int i = 0; i < LANES; i++) begin
            if (umask[i]) begin
               ui = int'(uidx[i*IDX_BITS +: IDX_BITS]);
               v  = m_now[i][ui];
               if (udir[i]) begin
                  if (v < W_MAXV) v++;
               end else begin
                  if (v > W_MINV) v--;
               end
               m_now[i][ui] = v;
            end
         end
      end
      if (clr && acc)
         zero_model();
      @(posedge clk);
      if (busy_cnt > 0)
         busy_cnt--;
      else if (clr)
         busy_cnt = CLR_CYC;
      @(negedge clk);
      drive_idle();
      checkOutput();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [LI-1:0] ridx);
      applyStimulus(1'b1, ridx, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic upd(input logic [LI-1:0] uidx, input logic [LANES-1:0] udir,
                      input logic [LANES-1:0] umask);
      applyStimulus(1'b0, '0, 1'b1, uidx, udir, umask, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      drive_idle();
      busy_cnt  = CLR_CYC;
      zero_model();
      exp_q.delete();
      exp_valid = 1'b0;
      last_w    = '0;
      #1;
      checkOutput();
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      drive_idle();
      #3;

      step = "reset";
      do_reset(2);

      step = "initial_clear";
      for (int k = 0; k < CLR_CYC; k++)
         applyStimulus(1'b1, idx_all(k), 1'b1, idx_all(k), '1, '1, 1'b0);

      step = "read_all_zero";
      for (int k = 0; k < DEPTH; k++) rd(idx_all(k));

      step = "sat_up";
      for (int n = 0; n < 4; n++) begin
         upd(idx_all(5), 4'b1111, 4'b0001);
         idle(1);
      end
      rd(idx_all(5));

      step = "sat_down";
      for (int n = 0; n < 8; n++) begin
         upd(idx_all(5), 4'b0000, 4'b0001);
         idle(1);
      end
      rd(idx_all(5));

      step = "clear_req";
      applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
      for (int k = 0; k < CLR_CYC; k++)
         applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, (k == 5));
      for (int k = 0; k < DEPTH; k++) rd(idx_all(k));

      step = "forward";
      upd(idx_all(5), 4'b1111, 4'b0001);
      upd(idx_all(5), 4'b1111, 4'b0001);
      for (int n = 0; n < 5; n++) upd(idx4(0, 0, 6, 0), 4'b0000, 4'b0100);
      idle(1);
      rd(idx4(5, 0, 6, 0));

      step = "mask";
      upd(idx_all(7), 4'b1111, 4'b0101);
      idle(1);
      rd(idx_all(7));

      step = "lane_indep";
      upd(idx_all(3), 4'b1111, 4'b0001);
      idle(1);
      rd(idx_all(3));
      upd(idx4(1, 2, 3, 4), 4'b0101, 4'b1111);
      idle(1);
      rd(idx4(1, 2, 3, 4));

      step = "reset_mid_clear";
      applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b0, '0, 1'b1, idx_all(k), '1, '1, 1'b0);
      do_reset(1);
      for (int k = 0; k < CLR_CYC; k++)
         applyStimulus(1'b1, idx_all(k), 1'b1, idx_all(k), '1, '1, 1'b0);
      for (int k = 0; k < DEPTH; k++) rd(idx_all(k));

      step = "bypass";
      upd(idx_all(5), 4'b1111, 4'b0001);
      rd(idx_all(5));
      rd(idx_all(5));
      applyStimulus(1'b1, idx_all(5), 1'b1, idx_all(5), 4'b1111, 4'b0001, 1'b0);
      rd(idx_all(5));
      rd(idx_all(5));

      step = "tail";
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
